// File: rtl/candy_ex_ctrl.sv
// Execute-stage controller: steers decoded ops to the ALU or divider, sequences the divider handshake,
// and drives a registered one-cycle register-file writeback. Optional macro: DIV0_BYPASS_EN.
module candy_ex_ctrl #(
    parameter int DATA_W = 24,
    parameter int ADDR_W = 5,
    parameter int OP_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic              div_i,
    input  logic              div_signed_i,
    input  logic              div_rem_i,
    input  logic [OP_W-1:0]   op_i,
    input  logic [DATA_W-1:0] src1_i,
    input  logic [DATA_W-1:0] src2_i,
    input  logic [ADDR_W-1:0] rd_i,
    input  logic              wreg_i,
    input  logic              flush_i,
    output logic [OP_W-1:0]   alu_op_o,
    output logic [DATA_W-1:0] alu_a_o,
    output logic [DATA_W-1:0] alu_b_o,
    input  logic [DATA_W-1:0] alu_res_i,
    output logic              div_start_o,
    output logic              div_annul_o,
    output logic              div_signed_o,
    output logic [DATA_W-1:0] div_op1_o,
    output logic [DATA_W-1:0] div_op2_o,
    input  logic              div_ready_i,
    input  logic [DATA_W-1:0] div_quot_i,
    // Divider remainder data; div_rem_i is the decode-side quotient/remainder select.
    input  logic [DATA_W-1:0] div_remainder_i,
    output logic              wb_we_o,
    output logic [ADDR_W-1:0] wb_waddr_o,
    output logic [DATA_W-1:0] wb_wdata_o,
    output logic              busy_o
);

    typedef enum logic {IDLE, DIV_WAIT} state_t;

    state_t            state;
    logic [ADDR_W-1:0] rd_q;
    logic              wreg_q;
    logic              rem_q;
    logic              accept;
    logic              bypass;

    assign ready_o = (state == IDLE);
    assign accept  = valid_i & ready_o & ~flush_i;

`ifdef DIV0_BYPASS_EN
    assign bypass = (src2_i == '0);
`else
    assign bypass = 1'b0;
`endif

    always_comb begin
        alu_op_o = '0;
        alu_a_o  = '0;
        alu_b_o  = '0;
        if (state == IDLE) begin
            alu_op_o = op_i;
            alu_a_o  = src1_i;
            alu_b_o  = src2_i;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            rd_q         <= '0;
            wreg_q       <= 1'b0;
            rem_q        <= 1'b0;
            wb_we_o      <= 1'b0;
            wb_waddr_o   <= '0;
            wb_wdata_o   <= '0;
            div_start_o  <= 1'b0;
            div_annul_o  <= 1'b0;
            div_signed_o <= 1'b0;
            div_op1_o    <= '0;
            div_op2_o    <= '0;
            busy_o       <= 1'b0;
        end else begin
            wb_we_o     <= 1'b0;
            div_annul_o <= 1'b0;
            if (state == IDLE) begin
                if (accept) begin
                    if (!div_i) begin
                        wb_we_o    <= wreg_i;
                        wb_waddr_o <= rd_i;
                        wb_wdata_o <= alu_res_i;
                    end else if (bypass) begin
                        wb_we_o    <= wreg_i;
                        wb_waddr_o <= rd_i;
                        wb_wdata_o <= div_rem_i ? src1_i : '1;
                    end else begin
                        div_op1_o    <= src1_i;
                        div_op2_o    <= src2_i;
                        div_signed_o <= div_signed_i;
                        rd_q         <= rd_i;
                        wreg_q       <= wreg_i;
                        rem_q        <= div_rem_i;
                        div_start_o  <= 1'b1;
                        busy_o       <= 1'b1;
                        state        <= DIV_WAIT;
                    end
                end
            end else begin
                // Flush wins over a result arriving in the same cycle.
                if (flush_i) begin
                    div_annul_o <= 1'b1;
                    div_start_o <= 1'b0;
                    busy_o      <= 1'b0;
                    state       <= IDLE;
                end else if (div_ready_i) begin
                    wb_we_o     <= wreg_q;
                    wb_waddr_o  <= rd_q;
                    wb_wdata_o  <= rem_q ? div_remainder_i : div_quot_i;
                    div_start_o <= 1'b0;
                    busy_o      <= 1'b0;
                    state       <= IDLE;
                end
            end
        end
    end

endmodule
